cp0_intr_ctrl: RTL and testbench
================================

// Module: cp0_intr_ctrl
// PURPOSE
//  CP0 interrupt/exception state block: Status, Cause, Count, Compare in one unit.
//  Generalises the EXL/IE/IM-only Status register to a parametrised number of hardware
//  interrupt lines, synchronised IRQ inputs, a prescaled Count/Compare timer and an int_req output.
//  Sits beside the CP0 file in WB; feeds int_req to the exception arbiter, rdata to MFC0.
// PARAMETERS
//  HW_INT_NUM   6  hardware interrupt lines (1..6); lines map to Cause.IP[2+i], unused IP bits read 0
//  SYNC_STAGES  2  synchroniser flops per hw_int line (1..3)
//  COUNT_DIV    2  clk cycles per Count increment (1..16)
// PORTS
//  clk          in   1           clock
//  rst_n        in   1           asynchronous active-low reset
//  mtc0_we      in   1           MTC0 write strobe (one cycle)
//  cp0_addr     in   7           {rd[4:0],sel[1:0]}: Count=0x24 Compare=0x2C Status=0x30 Cause=0x34
//  mtc0_data    in   32          MTC0 write data
//  exception    in   1           exception commit (one cycle)
//  exc_code     in   5           ExcCode for the committing exception
//  exc_bd       in   1           excepting instruction is in a delay slot
//  eret_flush   in   1           ERET commit (one cycle)
//  hw_int       in   HW_INT_NUM  asynchronous level interrupt lines, active high
//  cp0_rdata    out  32          MFC0 read data for cp0_addr, combinational; 0 for unmapped addr
//  status_data  out  32          Status register
//  cause_data   out  32          Cause register
//  int_req      out  1           IE & ~EXL & |(Cause.IP & Status.IM), combinational from registers
// BEHAVIOUR
//  Reset (async): Status=0x0040_0000 (BEV=1, EXL=0, IE=0, IM=0); Cause=0; Count=0; Compare=0;
//   prescaler=0; synchronisers=0; int_req=0.
//  Status: IE[0], EXL[1], IM[15:8] writable; BEV[22] constant 1; all other bits read 0.
//   EXL priority: exception (->1) > eret_flush (->0) > MTC0. IE/IM: MTC0 only.
//  Cause: BD[31], TI[30], IP[15:8], ExcCode[6:2]; others read 0.
//   exception: ExcCode<=exc_code; BD<=exc_bd only if Status.EXL==0 that cycle, else BD holds.
//   IP[1:0] writable by MTC0 only. IP[7:2] read-only: IP[2+i] = synchronised hw_int[i];
//   IP[7] = sync hw_int[5] (if present) | TI. hw_int edge to IP visible after SYNC_STAGES cycles.
//   MTC0 to Cause ignores all bits except IP[1:0].
//  Count: prescaler counts 0..COUNT_DIV-1; Count+1 on wrap; 0xFFFF_FFFF wraps to 0.
//   MTC0 Count: Count<=data, prescaler<=0; no increment that cycle.
//  Compare/TI: TI<=1 in the cycle after Count changes to a value equal to Compare.
//   MTC0 Compare: Compare<=data, TI<=0; the write wins over a same-cycle match.
//   TI holds until a Compare write or reset; eret/exception do not touch TI.
//  Same-cycle exception+eret_flush: exception wins for EXL; eret ignored.
//  Same-cycle exception+MTC0 Status: EXL<=1, IE/IM take written values.
//  int_req evaluates the post-update registers: one cycle after an MTC0 enabling IE.
//  Reset mid-operation: all state returns to reset values immediately, no pending interrupt retained.
// CONFIGURATION
//  CP0_TIMER_EN defined: Count, Compare, prescaler and TI implemented as above.
//  Not defined: no timer flops; Count/Compare read 0, writes ignored, TI constant 0,
//   IP[7] driven by hw_int[5] only.
// TESTING
//  1 Reset: rst_n low mid-run -> status_data=0x0040_0000, cause_data=0, int_req=0 without a clk edge.
//  2 MTC0 Status=0x0000_0401, hw_int[0]=1 -> Cause.IP2=1 after SYNC_STAGES cycles, int_req=1;
//    exception code 0 -> EXL=1, ExcCode=0, int_req=0; eret_flush -> EXL=0, int_req=1.
//  3 exception+eret_flush same cycle, exc_bd=1, EXL=0 -> EXL=1, BD=1; second exception exc_bd=0
//    while EXL=1 -> BD stays 1, ExcCode updated.
//  4 COUNT_DIV=2, write Count=5, Compare=8 -> Count=8 after 6 cycles, TI=1 next cycle, IP7=1;
//    write Compare=20 in the match cycle -> TI remains 0.
//  5 Count=0xFFFF_FFFF -> wraps to 0 after COUNT_DIV cycles; MTC0 Cause=0xFFFF_FFFF -> only IP[1:0] set.
//  6 Build without CP0_TIMER_EN: write Count=0x10 -> cp0_rdata at 0x24 reads 0, TI never sets.

Source files
------------

// File: rtl/cp0_intr_ctrl_if.sv
// CP0 interrupt/exception block bus: MTC0/MFC0 access, commit strobes,
// hardware interrupt lines and the Status/Cause/int_req outputs.
interface cp0_intr_ctrl_if #(
  parameter int HW_INT_NUM = 6
);
  logic                  mtc0_we;
  logic [6:0]            cp0_addr;
  logic [31:0]           mtc0_data;
  logic                  exception;
  logic [4:0]            exc_code;
  logic                  exc_bd;
  logic                  eret_flush;
  logic [HW_INT_NUM-1:0] hw_int;
  logic [31:0]           cp0_rdata;
  logic [31:0]           status_data;
  logic [31:0]           cause_data;
  logic                  int_req;

  modport master (
    output mtc0_we, cp0_addr, mtc0_data,
    output exception, exc_code, exc_bd,
    output eret_flush, hw_int,
    input  cp0_rdata, status_data,
    input  cause_data, int_req
  );

  modport slave (
    input  mtc0_we, cp0_addr, mtc0_data,
    input  exception, exc_code, exc_bd,
    input  eret_flush, hw_int,
    output cp0_rdata, status_data,
    output cause_data, int_req
  );
endinterface

// File: rtl/cp0_intr_ctrl.sv
// CP0 Status/Cause/Count/Compare state with synchronised IRQs and int_req.
// Optional timer (Count/Compare/TI) built only when CP0_TIMER_EN is defined.
module cp0_intr_ctrl #(
  parameter int HW_INT_NUM  = 6,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_DIV   = 2
) (
  input logic            clk,
  input logic            rst_n,
  cp0_intr_ctrl_if.slave bus
);

  localparam logic [6:0] A_COUNT   = 7'h24;
  localparam logic [6:0] A_COMPARE = 7'h2C;
  localparam logic [6:0] A_STATUS  = 7'h30;
  localparam logic [6:0] A_CAUSE   = 7'h34;

  logic wr_status;
  logic wr_cause;
  assign wr_status = bus.mtc0_we && (bus.cp0_addr == A_STATUS);
  assign wr_cause  = bus.mtc0_we && (bus.cp0_addr == A_CAUSE);

  logic [HW_INT_NUM-1:0] sync_q [SYNC_STAGES];

  // Synchroniser chain for the asynchronous hw_int lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_q[s] <= '0;
    end else begin
      sync_q[0] <= bus.hw_int;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
    end
  end

  logic [5:0] ip_hw;

  // Map synchronised lines onto IP[7:2]; absent lines read 0
  always_comb begin
    ip_hw = '0;
    ip_hw[HW_INT_NUM-1:0] = sync_q[SYNC_STAGES-1];
  end

  logic        ti;
  logic [31:0] count_rd;
  logic [31:0] compare_rd;

`ifdef CP0_TIMER_EN
  localparam logic [4:0] PRESC_MAX = 5'(COUNT_DIV - 1);

  logic        wr_count;
  logic        wr_compare;
  assign wr_count   = bus.mtc0_we && (bus.cp0_addr == A_COUNT);
  assign wr_compare = bus.mtc0_we && (bus.cp0_addr == A_COMPARE);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [4:0]  presc_q, presc_d;
  logic        chg_q, chg_d;
  logic        ti_q, ti_d;

  // Timer next state: prescaled Count, Compare, sticky TI
  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    presc_d   = presc_q;
    chg_d     = 1'b0;
    ti_d      = ti_q;
    if (wr_count) begin
      count_d = bus.mtc0_data;
      presc_d = '0;
      chg_d   = 1'b1;
    end else if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      count_d = count_q + 32'd1;
      chg_d   = 1'b1;
    end else begin
      presc_d = presc_q + 5'd1;
    end
    if (wr_compare)
      compare_d = bus.mtc0_data;
    if (wr_compare)
      ti_d = 1'b0;
    else if (chg_q && (count_q == compare_q))
      ti_d = 1'b1;
  end

  // Timer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      compare_q <= '0;
      presc_q   <= '0;
      chg_q     <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      presc_q   <= presc_d;
      chg_q     <= chg_d;
      ti_q      <= ti_d;
    end
  end

  assign ti         = ti_q;
  assign count_rd   = count_q;
  assign compare_rd = compare_q;
`else
  assign ti         = 1'b0;
  assign count_rd   = '0;
  assign compare_rd = '0;
`endif

  logic       ie_q, ie_d;
  logic       exl_q, exl_d;
  logic [7:0] im_q, im_d;
  logic       bd_q, bd_d;
  logic [1:0] ipsw_q, ipsw_d;
  logic [4:0] exc_q, exc_d;

  // Status/Cause next state; exception outranks eret for EXL
  always_comb begin
    ie_d   = ie_q;
    exl_d  = exl_q;
    im_d   = im_q;
    bd_d   = bd_q;
    ipsw_d = ipsw_q;
    exc_d  = exc_q;
    if (wr_status) begin
      ie_d  = bus.mtc0_data[0];
      exl_d = bus.mtc0_data[1];
      im_d  = bus.mtc0_data[15:8];
    end
    if (bus.exception)
      exl_d = 1'b1;
    else if (bus.eret_flush)
      exl_d = 1'b0;
    if (wr_cause)
      ipsw_d = bus.mtc0_data[9:8];
    if (bus.exception) begin
      exc_d = bus.exc_code;
      if (!exl_q)
        bd_d = bus.exc_bd;
    end
  end

  // Status/Cause state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q   <= 1'b0;
      exl_q  <= 1'b0;
      im_q   <= '0;
      bd_q   <= 1'b0;
      ipsw_q <= '0;
      exc_q  <= '0;
    end else begin
      ie_q   <= ie_d;
      exl_q  <= exl_d;
      im_q   <= im_d;
      bd_q   <= bd_d;
      ipsw_q <= ipsw_d;
      exc_q  <= exc_d;
    end
  end

  logic [7:0]  ip;
  logic [31:0] status;
  logic [31:0] cause;

  assign ip = {ip_hw[5] | ti, ip_hw[4:0], ipsw_q};

  assign status = {9'd0, 1'b1, 6'd0, im_q,
                   6'd0, exl_q, ie_q};
  assign cause  = {bd_q, ti, 14'd0, ip,
                   1'b0, exc_q, 2'b00};

  assign bus.status_data = status;
  assign bus.cause_data  = cause;
  assign bus.int_req     = ie_q & ~exl_q & (|(ip & im_q));

  // MFC0 read mux
  always_comb begin
    case (bus.cp0_addr)
      A_COUNT:   bus.cp0_rdata = count_rd;
      A_COMPARE: bus.cp0_rdata = compare_rd;
      A_STATUS:  bus.cp0_rdata = status;
      A_CAUSE:   bus.cp0_rdata = cause;
      default:   bus.cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// Testbench for cp0_intr_ctrl: vector table plus timer/reset sequences.
// Timer checks follow the CP0_TIMER_EN build setting.
module tb_cp0_intr_ctrl;

  localparam int HWN = 6;

  logic clk;
  logic rst_n;

  cp0_intr_ctrl_if #(.HW_INT_NUM(HWN)) bus ();

  cp0_intr_ctrl #(
    .HW_INT_NUM (HWN),
    .SYNC_STAGES(2),
    .COUNT_DIV  (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [31:0] data;
    logic        exc;
    logic [4:0]  code;
    logic        bd;
    logic        eret;
    logic [5:0]  hw;
    logic [31:0] exp_st;
    logic [31:0] exp_ca;
    logic        exp_int;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  int checks;
  int failures;

  function automatic vec_t mk(
    logic we, logic [6:0] a, logic [31:0] d,
    logic ex, logic [4:0] c, logic b,
    logic er, logic [5:0] h,
    logic [31:0] es, logic [31:0] ec, logic ei);
    vec_t v;
    v.we = we; v.addr = a; v.data = d;
    v.exc = ex; v.code = c; v.bd = b;
    v.eret = er; v.hw = h;
    v.exp_st = es; v.exp_ca = ec; v.exp_int = ei;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h",
               nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.mtc0_we    = 1'b0;
    bus.exception  = 1'b0;
    bus.eret_flush = 1'b0;
    bus.exc_bd     = 1'b0;
  endtask

  task automatic mtc0(logic [6:0] a, logic [31:0] d);
    bus.mtc0_we   = 1'b1;
    bus.cp0_addr  = a;
    bus.mtc0_data = d;
    cyc();
    clr();
  endtask

  task automatic rd(logic [6:0] a, output logic [31:0] d);
    bus.cp0_addr = a;
    #1;
    d = bus.cp0_rdata;
  endtask

  logic [31:0] r;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.mtc0_we    = 1'b0;
    bus.cp0_addr   = 7'h00;
    bus.mtc0_data  = '0;
    bus.exception  = 1'b0;
    bus.exc_code   = '0;
    bus.exc_bd     = 1'b0;
    bus.eret_flush = 1'b0;
    bus.hw_int     = '0;

    //       we   addr   data          ex c  bd er hw     status        cause         int
    tbl[0]  = mk(1, 7'h30, 32'h0000_0401, 0, 0, 0, 0, 6'h00, 32'h0040_0401, 32'h0000_0000, 0);
    tbl[1]  = mk(0, 7'h00, 32'h0,         0, 0, 0, 0, 6'h01, 32'h0040_0401, 32'h0000_0000, 0);
    tbl[2]  = mk(0, 7'h00, 32'h0,         0, 0, 0, 0, 6'h01, 32'h0040_0401, 32'h0000_0400, 1);
    tbl[3]  = mk(0, 7'h00, 32'h0,         1, 0, 0, 0, 6'h01, 32'h0040_0403, 32'h0000_0400, 0);
    tbl[4]  = mk(0, 7'h00, 32'h0,         0, 0, 0, 1, 6'h01, 32'h0040_0401, 32'h0000_0400, 1);
    tbl[5]  = mk(0, 7'h00, 32'h0,         1, 5, 1, 1, 6'h00, 32'h0040_0403, 32'h8000_0414, 0);
    tbl[6]  = mk(0, 7'h00, 32'h0,         1, 8, 0, 0, 6'h00, 32'h0040_0403, 32'h8000_0020, 0);
    tbl[7]  = mk(1, 7'h34, 32'hFFFF_FFFF, 0, 0, 0, 0, 6'h00, 32'h0040_0403, 32'h8000_0320, 0);
    tbl[8]  = mk(1, 7'h30, 32'h0000_FF01, 1, 3, 0, 0, 6'h00, 32'h0040_FF03, 32'h8000_030C, 0);
    tbl[9]  = mk(0, 7'h00, 32'h0,         0, 0, 0, 1, 6'h00, 32'h0040_FF01, 32'h8000_030C, 1);
    tbl[10] = mk(1, 7'h30, 32'h0000_0000, 0, 0, 0, 0, 6'h00, 32'h0040_0000, 32'h8000_030C, 0);
    tbl[11] = mk(1, 7'h30, 32'hFFFF_FFFF, 0, 0, 0, 0, 6'h00, 32'h0040_FF03, 32'h8000_030C, 0);
    tbl[12] = mk(1, 7'h34, 32'h0000_0000, 0, 0, 0, 0, 6'h00, 32'h0040_FF03, 32'h8000_000C, 0);
    tbl[13] = mk(0, 7'h00, 32'h0,         0, 0, 0, 0, 6'h20, 32'h0040_FF03, 32'h8000_000C, 0);
    tbl[14] = mk(0, 7'h00, 32'h0,         0, 0, 0, 0, 6'h20, 32'h0040_FF03, 32'h8000_800C, 0);
    tbl[15] = mk(0, 7'h00, 32'h0,         0, 0, 0, 1, 6'h20, 32'h0040_FF01, 32'h8000_800C, 1);
    tbl[16] = mk(0, 7'h00, 32'h0,         0, 0, 0, 0, 6'h00, 32'h0040_FF01, 32'h8000_800C, 1);
    tbl[17] = mk(0, 7'h00, 32'h0,         0, 0, 0, 0, 6'h00, 32'h0040_FF01, 32'h8000_000C, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_status", bus.status_data, 32'h0040_0000);
    chk("rst_cause", bus.cause_data, 32'h0);
    chk("rst_int", {31'd0, bus.int_req}, 32'h0);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < NV; i++) begin
      bus.mtc0_we    = tbl[i].we;
      bus.cp0_addr   = tbl[i].addr;
      bus.mtc0_data  = tbl[i].data;
      bus.exception  = tbl[i].exc;
      bus.exc_code   = tbl[i].code;
      bus.exc_bd     = tbl[i].bd;
      bus.eret_flush = tbl[i].eret;
      bus.hw_int     = tbl[i].hw;
      cyc();
      clr();
      chk($sformatf("v%0d_status", i),
          bus.status_data, tbl[i].exp_st);
      chk($sformatf("v%0d_cause", i),
          bus.cause_data, tbl[i].exp_ca);
      chk($sformatf("v%0d_int", i),
          {31'd0, bus.int_req}, {31'd0, tbl[i].exp_int});
    end

    rd(7'h30, r);
    chk("rd_status", r, 32'h0040_FF01);
    rd(7'h34, r);
    chk("rd_cause", r, 32'h8000_000C);
    rd(7'h00, r);
    chk("rd_unmapped", r, 32'h0);

`ifdef CP0_TIMER_EN
    mtc0(7'h24, 32'h0000_0100);
    mtc0(7'h2C, 32'd8);
    mtc0(7'h24, 32'd5);
    rd(7'h24, r);
    chk("cnt_wr", r, 32'd5);
    repeat (6) cyc();
    rd(7'h24, r);
    chk("cnt_at8", r, 32'd8);
    chk("ti_not_yet", bus.cause_data, 32'h8000_000C);
    cyc();
    chk("ti_set", bus.cause_data, 32'hC000_800C);
    chk("ti_int", {31'd0, bus.int_req}, 32'd1);

    mtc0(7'h2C, 32'd8);
    chk("ti_clr", bus.cause_data, 32'h8000_000C);
    mtc0(7'h24, 32'd5);
    repeat (6) cyc();
    rd(7'h24, r);
    chk("cnt_at8b", r, 32'd8);
    mtc0(7'h2C, 32'd20);
    chk("ti_race", bus.cause_data, 32'h8000_000C);
    repeat (3) cyc();
    chk("ti_race_hold", bus.cause_data, 32'h8000_000C);

    mtc0(7'h24, 32'hFFFF_FFFF);
    rd(7'h24, r);
    chk("wrap_pre", r, 32'hFFFF_FFFF);
    cyc();
    rd(7'h24, r);
    chk("wrap_mid", r, 32'hFFFF_FFFF);
    cyc();
    rd(7'h24, r);
    chk("wrap_zero", r, 32'h0);
`else
    mtc0(7'h24, 32'h0000_0010);
    rd(7'h24, r);
    chk("nt_count", r, 32'h0);
    mtc0(7'h2C, 32'h0000_0010);
    rd(7'h2C, r);
    chk("nt_compare", r, 32'h0);
    repeat (40) cyc();
    chk("nt_no_ti", bus.cause_data, 32'h8000_000C);
`endif

    mtc0(7'h34, 32'h0000_0300);
    bus.hw_int = 6'h01;
    repeat (3) cyc();
    chk("pre_rst_cause", bus.cause_data, 32'h8000_070C);
    chk("pre_rst_int", {31'd0, bus.int_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_status", bus.status_data, 32'h0040_0000);
    chk("mid_rst_cause", bus.cause_data, 32'h0);
    chk("mid_rst_int", {31'd0, bus.int_req}, 32'h0);
    rd(7'h24, r);
    chk("mid_rst_count", r, 32'h0);
    bus.hw_int = '0;
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
